// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks register-file test port FIRST_REG..LAST_REG and streams
// HEADER, then {idx, data[7:0..31:24]} per register over valid/ready.
// Ports: inclk/rstn clock and async active-low reset; start dump request;
// test_addr/test_data register-file test port; tx_data/tx_valid/tx_ready
// byte stream; busy high outside IDLE; done one-cycle frame-complete pulse.
module reg_dump_tx #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        inclk,
  input  logic        rstn,
  input  logic        start,
  output logic [31:0] test_addr,
  input  logic [31:0] test_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  if (LAST_REG < FIRST_REG || LAST_REG > 31) begin : g_bad_range
    $error("reg_dump_tx: invalid FIRST_REG/LAST_REG");
  end

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  // Outputs decode from state flops only, so a reset clears them
  // without waiting for a clock edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    test_addr = {27'b0, idx_q};
    tx_data   = '0;
    tx_valid  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        test_addr = '0;
        if (start) begin
          state_d = HDR;
          idx_d   = FIRST_IDX;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) state_d = LOAD;
      end
      LOAD: begin
        snap_d  = test_data;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        unique case (cnt_q)
          3'd0:    tx_data = {3'b0, idx_q};
          3'd1:    tx_data = snap_q[7:0];
          3'd2:    tx_data = snap_q[15:8];
          3'd3:    tx_data = snap_q[23:16];
          3'd4:    tx_data = snap_q[31:24];
          default: tx_data = '0;
        endcase
        if (tx_ready) begin
          if (cnt_q == 3'd4) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
Debug read-out engine for the register file's test port. On a start pulse it walks register indices FIRST_REG..LAST_REG, driving test_addr and sampling test_data. It serialises each register as a byte stream over a valid/ready interface for a UART or host bridge. It is the reader on the test interface; the CPU datapath remains the writer.

Parameters:
FIRST_REG, 0, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG..31)
HEADER, 8'hA5, frame-start byte sent before the first register

Ports:
inclk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  dump request, sampled on the rising edge, level or pulse
test_addr  output  32  register index driven to the register file test port; bits [31:5] always 0
test_data  input  32  combinational register contents for test_addr
tx_data  output  8  stream byte
tx_valid  output  1  tx_data is valid
tx_ready  input  1  sink accepts the byte
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Clock and reset: single clock inclk; rstn asynchronous, active-low.
- Reset values: state=IDLE, test_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, idx=0, byte count=0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). No partial-frame recovery. The next start begins a fresh frame.
- Transfer rule: a byte transfers on a rising edge where tx_valid && tx_ready.
  - Once asserted, tx_valid stays high and tx_data stays stable until the transfer.
  - tx_valid never depends combinationally on tx_ready.
- Frame format: HEADER, then for each idx from FIRST_REG to LAST_REG: idx byte ({3'b0, idx}), then the data word little-endian (bits [7:0], [15:8], [23:16], [31:24]).
- Frame length: 1 + 5*(LAST_REG-FIRST_REG+1) bytes.
- States:
  - IDLE: test_addr=0. When start=1, go to HDR and set idx=FIRST_REG.
  - HDR: tx_valid=1, tx_data=HEADER. On transfer, go to LOAD.
  - LOAD (1 cycle, tx_valid=0): test_addr=idx. At the clock edge, capture test_data into a 32-bit snapshot register, then go to SEND with byte count=0.
  - SEND: tx_valid=1. Byte count 0 sends idx; counts 1..4 send the snapshot bytes, LSB first. Each transfer increments the count.
    - After count 4 transfers with idx==LAST_REG, go to DONE.
    - After count 4 transfers otherwise, increment idx and go to LOAD.
  - DONE (1 cycle): done=1, tx_valid=0. Then go to IDLE.
- Snapshot: a register-file write to idx after LOAD does not alter bytes already captured. Values are coherent per register only, not across the whole frame.
- start while busy: ignored, no restart and no queueing. A start held high in DONE is not seen. A start held high in IDLE after DONE launches a new frame.
- test_addr holds the idx last loaded during HDR, SEND and DONE. It returns to 0 in IDLE.
- Latency with tx_ready held at 1:
  - HDR appears on tx the cycle after start is sampled.
  - Each register takes 6 cycles (LOAD plus 5 bytes).
  - done pulses 1 cycle after the last byte transfers.
  - For 0..31: start edge to done = 1 + 192 + 1 cycles.
- Parameter violation (LAST_REG<FIRST_REG or either >31): not supported. The simulation model flags an error at time 0.

Test Plan:
- Full dump with ready=1, regs preloaded r[i]=i*32'h01010101 and r1=32'h12345678: 161 bytes. The stream starts A5,00,00,00,00,00,01,78,56,34,12. done pulses exactly once, at cycle 194 after start. busy falls the cycle after done.
- Backpressure: tx_ready toggles randomly, ~50%. Stream content is identical to the ready=1 run. tx_data is stable and tx_valid never drops while valid && !ready. No byte is lost or duplicated.
- Snapshot: FIRST_REG=LAST_REG=5, r5=32'hDEADBEEF. In the SEND state, with tx_ready=0, write r5=0. Stream is A5,05,EF,BE,AD,DE, then done.
- Start while busy: pulse start at bytes 3 and 50 of a frame. Exactly one frame is produced and done pulses once. start held high continuously yields back-to-back frames with one IDLE cycle between done and the next HDR.
- Reset mid-frame: deassert rstn during SEND of reg 10. tx_valid, busy and done go to 0 without waiting for a clock edge. After release and a start, a complete frame begins with A5,00.
- Port idle checks: test_addr=0 and tx_valid=0 in IDLE. test_addr[31:5]=0 at all times.
